// File: rtl/reg_file_multi_if.sv
// Bus between the CPU pipeline and the multi-port register file.
// Decode/writeback drive the master side; the register file is the slave.
interface reg_file_multi_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NRD    = 2
);
    logic [DATA_W-1:0]     IN;
    logic [ADDR_W-1:0]     INADDRESS;
    logic                  WRITE;
    logic                  BUSYWAIT;
    logic [NRD*ADDR_W-1:0] OUTADDR;
    logic [NRD*DATA_W-1:0] OUT;
    logic                  READY;

    modport master (
        output IN, INADDRESS, WRITE, BUSYWAIT, OUTADDR,
        input  OUT, READY
    );

    modport slave (
        input  IN, INADDRESS, WRITE, BUSYWAIT, OUTADDR,
        output OUT, READY
    );
endinterface

// File: rtl/reg_file_multi.sv
// Multi-read-port register file with write-to-read forwarding, optional
// hard-wired zero register and a one-register-per-cycle clear engine.
module reg_file_multi #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0
) (
    input logic              CLK,
    input logic              RESET_N,
    reg_file_multi_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic                  we;
    logic                  wr_zero;
    logic [ADDR_W-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] out_d;

    always_comb begin
        we      = bus.WRITE & ~bus.BUSYWAIT & RESET_N & (state_q == RUN);
        wr_zero = (ZERO_REG != 0) && (bus.INADDRESS == '0);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        regs_d  = regs_q;
        if (state_q == CLEAR) begin
            regs_d[ptr_q] = '0;
            ptr_d         = ptr_q + ADDR_W'(1);
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end else if (we && !wr_zero) begin
            regs_d[bus.INADDRESS] = bus.IN;
        end
    end

    // Reset only restarts the clear; register contents are left for the engine to wipe.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        out_d   = '0;
        rd_addr = '0;
        if (state_q == RUN) begin
            for (int k = 0; k < NRD; k++) begin
                rd_addr = bus.OUTADDR[k*ADDR_W +: ADDR_W];
                if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                    out_d[k*DATA_W +: DATA_W] = '0;
                end else if (we && (bus.INADDRESS == rd_addr)) begin
                    out_d[k*DATA_W +: DATA_W] = bus.IN;
                end else begin
                    out_d[k*DATA_W +: DATA_W] = regs_q[rd_addr];
                end
            end
        end
    end

    assign bus.OUT   = out_d;
    assign bus.READY = (state_q == RUN);
endmodule

// File: tb/tb_reg_file_multi.sv
// Self-checking bench for reg_file_multi: a default 8-bit/2-port instance and a
// 16-bit/3-port instance with the zero register enabled, sharing clock and reset.
module tb_reg_file_multi;
    logic CLK;
    logic RESET_N;

    int tests_run;
    int tests_failed;

    reg_file_multi_if #(.DATA_W(8),  .ADDR_W(3), .NRD(2)) bus_a ();
    reg_file_multi_if #(.DATA_W(16), .ADDR_W(3), .NRD(3)) bus_b ();

    reg_file_multi #(.DATA_W(8), .ADDR_W(3), .NRD(2), .ZERO_REG(0)) dut_a (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_a)
    );

    reg_file_multi #(.DATA_W(16), .ADDR_W(3), .NRD(3), .ZERO_REG(1)) dut_b (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model of the default instance: plain array of register contents.
    logic [7:0] model_mem [8];

    typedef struct {
        logic       wr;
        logic       busy;
        logic [2:0] ia;
        logic [7:0] d;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic busy, input logic [2:0] ia,
                                 input logic [7:0] d, input logic [2:0] a0, input logic [2:0] a1);
        bus_a.WRITE     = wr;
        bus_a.BUSYWAIT  = busy;
        bus_a.INADDRESS = ia;
        bus_a.IN        = d;
        bus_a.OUTADDR   = {a1, a0};
        #1;
    endtask

    function automatic logic [7:0] modelRead(input logic wr, input logic busy, input logic [2:0] ia,
                                             input logic [7:0] d, input logic [2:0] a);
        if (wr && !busy && ia == a) return d;
        return model_mem[a];
    endfunction

    task automatic commitModel(input logic wr, input logic busy, input logic [2:0] ia, input logic [7:0] d);
        if (wr && !busy) model_mem[ia] = d;
    endtask

    task automatic idleInputs();
        bus_a.WRITE = 1'b0; bus_a.BUSYWAIT = 1'b0; bus_a.INADDRESS = '0; bus_a.IN = '0; bus_a.OUTADDR = '0;
        bus_b.WRITE = 1'b0; bus_b.BUSYWAIT = 1'b0; bus_b.INADDRESS = '0; bus_b.IN = '0; bus_b.OUTADDR = '0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idleInputs();
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;

        // Reset for two cycles, then count the clear.
        RESET_N = 1'b0;
        tick();
        tick();
        checkOutput("reset_ready_a", {63'd0, bus_a.READY}, 64'd0);
        checkOutput("reset_ready_b", {63'd0, bus_b.READY}, 64'd0);
        checkOutput("reset_out_a", {48'd0, bus_a.OUT}, 64'd0);
        RESET_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("clear_ready_low_%0d", i), {63'd0, bus_a.READY}, 64'd0);
            tick();
        end
        checkOutput("clear_ready_high_a", {63'd0, bus_a.READY}, 64'd1);
        checkOutput("clear_ready_high_b", {63'd0, bus_b.READY}, 64'd1);
        for (int a = 0; a < 8; a++) begin
            bus_a.OUTADDR = {3'(7 - a), 3'(a)};
            #1;
            checkOutput($sformatf("default_zero_%0d", a), {48'd0, bus_a.OUT}, 64'd0);
        end

        // Directed table: forwarding, busywait blocking, per-port independence.
        vecs[0] = '{1'b1, 1'b0, 3'd3, 8'hA5, 3'd3, 3'd0, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 3'd3, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 3'd5, 8'h3C, 3'd5, 3'd3, 8'h00, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 3'd5, 8'h3C, 3'd5, 3'd5, 8'h3C, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 8'h3C, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 3'd0, 8'hFF, 3'd0, 3'd7, 8'hFF, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd6, 8'hFF, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 3'd3, 8'h11, 3'd3, 3'd5, 8'h11, 8'h3C};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].busy, vecs[i].ia, vecs[i].d, vecs[i].a0, vecs[i].a1);
            checkOutput($sformatf("vec%0d_port0", i), {56'd0, bus_a.OUT[7:0]},  {56'd0, vecs[i].e0});
            checkOutput($sformatf("vec%0d_port1", i), {56'd0, bus_a.OUT[15:8]}, {56'd0, vecs[i].e1});
            commitModel(vecs[i].wr, vecs[i].busy, vecs[i].ia, vecs[i].d);
            tick();
        end

        // Random traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            logic       wr, busy;
            logic [2:0] ia, a0, a1;
            logic [7:0] d;
            wr   = ($urandom_range(0, 1) == 1);
            busy = ($urandom_range(0, 3) == 0);
            ia   = 3'($urandom_range(0, 7));
            d    = 8'($urandom);
            a0   = ($urandom_range(0, 3) == 0) ? ia : 3'($urandom_range(0, 7));
            a1   = ($urandom_range(0, 3) == 0) ? a0 : 3'($urandom_range(0, 7));
            applyStimulus(wr, busy, ia, d, a0, a1);
            checkOutput("rand_port0", {56'd0, bus_a.OUT[7:0]},  {56'd0, modelRead(wr, busy, ia, d, a0)});
            checkOutput("rand_port1", {56'd0, bus_a.OUT[15:8]}, {56'd0, modelRead(wr, busy, ia, d, a1)});
            commitModel(wr, busy, ia, d);
            tick();
        end
        idleInputs();

        // Reset mid-clear with a write attempt during the clear.
        model_mem[1] = 8'h5A;
        applyStimulus(1'b1, 1'b0, 3'd1, 8'h5A, 3'd1, 3'd1);
        tick();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        bus_a.OUTADDR = {3'd5, 3'd3};
        bus_a.WRITE   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus_a.WRITE = 1'b1; bus_a.INADDRESS = 3'd1; bus_a.IN = 8'h77;
            end else begin
                bus_a.WRITE = 1'b0;
            end
            #1;
            checkOutput($sformatf("midclear_ready_%0d", i), {63'd0, bus_a.READY}, 64'd0);
            checkOutput($sformatf("midclear_out_%0d", i), {48'd0, bus_a.OUT}, 64'd0);
            tick();
        end
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("reclear_ready_low_%0d", i), {63'd0, bus_a.READY}, 64'd0);
            tick();
        end
        checkOutput("reclear_ready_high", {63'd0, bus_a.READY}, 64'd1);
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd3);
        checkOutput("lost_clear_write", {56'd0, bus_a.OUT[7:0]}, {56'd0, model_mem[1]});
        checkOutput("reclear_addr3", {56'd0, bus_a.OUT[15:8]}, {56'd0, model_mem[3]});

        // Zero-register instance: writes to 0 dropped, reads of 0 always zero.
        bus_b.WRITE = 1'b1; bus_b.INADDRESS = 3'd0; bus_b.IN = 16'hFFFF;
        bus_b.OUTADDR = {3'd0, 3'd0, 3'd0};
        #1;
        checkOutput("zero_same_cycle", {16'd0, bus_b.OUT}, 64'd0);
        tick();
        bus_b.WRITE = 1'b0;
        #1;
        checkOutput("zero_after_edge", {16'd0, bus_b.OUT}, 64'd0);

        bus_b.WRITE = 1'b1; bus_b.INADDRESS = 3'd6; bus_b.IN = 16'hBEEF;
        bus_b.OUTADDR = {3'd6, 3'd6, 3'd6};
        #1;
        checkOutput("wide_forward", {16'd0, bus_b.OUT}, {16'd0, 16'hBEEF, 16'hBEEF, 16'hBEEF});
        tick();
        bus_b.WRITE = 1'b1; bus_b.INADDRESS = 3'd2; bus_b.IN = 16'h1234;
        bus_b.OUTADDR = {3'd0, 3'd2, 3'd6};
        #1;
        checkOutput("wide_mixed_fwd", {16'd0, bus_b.OUT}, {16'd0, 16'h0000, 16'h1234, 16'hBEEF});
        tick();
        bus_b.WRITE = 1'b1; bus_b.BUSYWAIT = 1'b1; bus_b.INADDRESS = 3'd6; bus_b.IN = 16'h0BAD;
        bus_b.OUTADDR = {3'd6, 3'd2, 3'd6};
        #1;
        checkOutput("wide_busy_nofwd", {16'd0, bus_b.OUT}, {16'd0, 16'hBEEF, 16'h1234, 16'hBEEF});
        tick();
        bus_b.WRITE = 1'b0; bus_b.BUSYWAIT = 1'b0;
        #1;
        checkOutput("wide_busy_held", {16'd0, bus_b.OUT}, {16'd0, 16'hBEEF, 16'h1234, 16'hBEEF});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
